// File: rtl/ext_mem_bridge_pkg.sv
// Shared definitions for the external memory bridge: state encoding and counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ext_mem_bridge_pkg;

   // Default bus widths used by the internal bus stage upstream.
   localparam int ADDR_SIZE  = 32;
   localparam int DATA_SIZE  = 32;

   // Width of the wait-state counter and of the mem_rdy timeout counter.
   localparam int WAIT_CNT_W = 8;
   localparam int TMO_CNT_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ACC  = 3'd1,
      ST_WR_ACC  = 3'd2,
      ST_RD_DONE = 3'd3,
      ST_WR_DONE = 3'd4,
      ST_ERR     = 3'd5
   } state_t;

endpackage

// File: rtl/mem_wait_ctr.sv
// Wait-state and mem_rdy timeout counter for one memory access.
// Latency: min_met rises wait_min cycles after load drops; tmo_hit is combinational on the TMO-th stall cycle.
// Backpressure: stall cycles (rdy low after min_met) are counted; counting freezes at the timeout value.
module mem_wait_ctr
   import ext_mem_bridge_pkg::*;
#(
   parameter int TMO = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  en,
   input  logic                  rdy,
   input  logic [WAIT_CNT_W-1:0] wait_min,
   output logic                  min_met,
   output logic                  tmo_hit
);

   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TMO - 1);

   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic [TMO_CNT_W-1:0]  stall_cnt;

   // wait_cnt holds the number of access cycles already elapsed, so the
   // minimum is met once it has reached the programmed threshold.
   assign min_met = (wait_cnt >= wait_min);
   assign tmo_hit = en && min_met && !rdy && (stall_cnt == TMO_LAST);

   // Count wait states first, then stalled cycles; load clears both between accesses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt  <= '0;
         stall_cnt <= '0;
      end else if (load) begin
         wait_cnt  <= '0;
         stall_cnt <= '0;
      end else if (en) begin
         if (!min_met) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else if (!rdy && (stall_cnt != TMO_LAST)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ext_mem_bridge.sv
// 4-phase read/write responder driving a synchronous SRAM-style memory port.
// Latency: done rises RD_WAIT/WR_WAIT cycles after the request is sampled, plus any mem_rdy stall cycles.
// Backpressure: mem_rdy stretches the access; TMO stalled cycles give a bus_err pulse and an empty completion.
module ext_mem_bridge
   import ext_mem_bridge_pkg::*;
#(
   parameter int ADDR_W  = ADDR_SIZE,
   parameter int DATA_W  = DATA_SIZE,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 1,
   parameter int TMO     = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_q,
   input  logic              write_q,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              read_dn,
   output logic              write_dn,
   output logic              bus_busy,
   output logic              bus_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rdy
);

   // Thresholds are "cycles elapsed before completion may happen", hence the -1.
   localparam logic [WAIT_CNT_W-1:0] RD_MIN = WAIT_CNT_W'(RD_WAIT - 1);
   localparam logic [WAIT_CNT_W-1:0] WR_MIN = WAIT_CNT_W'(WR_WAIT - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] rdata_q;
   logic              op_wr;
   logic              in_acc;
   logic              min_met;
   logic              tmo_hit;

   assign in_acc = (state == ST_RD_ACC) || (state == ST_WR_ACC);

   mem_wait_ctr #(
      .TMO (TMO)
   ) u_wait_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (state == ST_IDLE),
      .en       (in_acc),
      .rdy      (mem_rdy),
      .wait_min (op_wr ? WR_MIN : RD_MIN),
      .min_met  (min_met),
      .tmo_hit  (tmo_hit)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; writes win over reads in IDLE since the read stays held.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (write_q) begin
               state_nxt = ST_WR_ACC;
            end else if (read_q) begin
               state_nxt = ST_RD_ACC;
            end
         end
         ST_RD_ACC: begin
            if (min_met && mem_rdy) begin
               state_nxt = ST_RD_DONE;
            end else if (tmo_hit) begin
               state_nxt = ST_ERR;
            end
         end
         ST_WR_ACC: begin
            if (min_met && mem_rdy) begin
               state_nxt = ST_WR_DONE;
            end else if (tmo_hit) begin
               state_nxt = ST_ERR;
            end
         end
         ST_ERR: begin
            state_nxt = op_wr ? ST_WR_DONE : ST_RD_DONE;
         end
         ST_RD_DONE: begin
            if (!read_q) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WR_DONE: begin
            if (!write_q) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Strobes and status flags are flops loaded from the next state, so they never glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_re   <= 1'b0;
         mem_we   <= 1'b0;
         read_dn  <= 1'b0;
         write_dn <= 1'b0;
         bus_busy <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         mem_re   <= (state_nxt == ST_RD_ACC);
         mem_we   <= (state_nxt == ST_WR_ACC);
         read_dn  <= (state_nxt == ST_RD_DONE);
         write_dn <= (state_nxt == ST_WR_DONE);
         bus_busy <= (state_nxt != ST_IDLE);
         bus_err  <= (state_nxt == ST_ERR);
      end
   end

   // Request capture in IDLE and read-data capture on completion; a timed-out read keeps zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         op_wr   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               rdata_q <= '0;
               if (write_q) begin
                  addr_q <= addr_in;
                  data_q <= data_in;
                  op_wr  <= 1'b1;
               end else if (read_q) begin
                  addr_q <= addr_in;
                  op_wr  <= 1'b0;
               end
            end
            ST_RD_ACC: begin
               if (min_met && mem_rdy) begin
                  rdata_q <= mem_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Upstream buses are OR-combined, so every data/address output is zero outside its valid state.
   assign data_out  = read_dn ? rdata_q : '0;
   assign mem_addr  = (mem_re || mem_we) ? addr_q : '0;
   assign mem_wdata = mem_we ? data_q : '0;

endmodule
